branch_commit_queue: RTL and testbench

In-order tracker for in-flight conditional branches, sitting between fetch/issue, the execution units and the branch predictor. It records each branch when it is allocated, collects its out-of-order resolution, and retires branches in program order. On retirement it drives the predictor's update port (`ROB_valid` / `ins_pc`, where `ins_pc[0]` is the actual taken bit). On a misprediction it raises a single redirect and clears all younger state.

---
 rtl/branch_commit_queue_if.sv | 42 ++++
 rtl/branch_commit_queue.sv | 125 ++++++++++++
 tb/tb_branch_commit_queue.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_commit_queue_if.sv
// branch_commit_queue_if
// Bundles the allocate, resolve, predictor-update and redirect signals of the
// branch commit queue.
//   master : fetch/issue + execution side (drives alloc_* and res_*)
//   slave  : the queue itself (drives alloc_ready/alloc_tag, upd_*, flush_*, count)
// Allocation handshake: an allocation transfers on a rising clk_in edge with
// rdy_in high when alloc_valid && alloc_ready; while alloc_ready is low the
// source must keep alloc_valid and its payload stable until it is accepted.
// res_valid, upd_valid and flush_valid are single-cycle strobes with no
// back-pressure.
interface branch_commit_queue_if #(
    parameter int TAG_W = 4
);
    logic             alloc_valid;
    logic [31:0]      alloc_pc;
    logic [31:0]      alloc_pred_pc;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             flush_valid;
    logic [31:0]      flush_pc;
    logic [TAG_W:0]   count;

    modport master (
        output alloc_valid, alloc_pc, alloc_pred_pc,
        output res_valid, res_tag, res_taken, res_target,
        input  alloc_ready, alloc_tag, upd_valid, upd_pc,
        input  flush_valid, flush_pc, count
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_pc,
        input  res_valid, res_tag, res_taken, res_target,
        output alloc_ready, alloc_tag, upd_valid, upd_pc,
        output flush_valid, flush_pc, count
    );
endinterface

// File: rtl/branch_commit_queue.sv
// branch_commit_queue
// In-order tracker for in-flight conditional branches. Branches are allocated
// at the tail, resolved out of order by tag, and retired one per cycle from the
// head. Each retirement emits a predictor update (upd_pc[0] = actual taken);
// a retirement whose resolved target differs from the predicted next PC also
// emits a redirect and empties the queue.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous active-high reset
//   rdy_in  : global ready; when low every register (including pulses) holds
//   bus     : branch_commit_queue_if.slave (allocate / resolve / update / flush)
module branch_commit_queue #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    branch_commit_queue_if.slave  bus
);
    localparam logic [TAG_W:0]   FULL    = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] PTR_ONE = TAG_W'(1);

    // Control state (reset)
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] resolved_q;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count_q;
    logic             upd_valid_q;
    logic [31:0]      upd_pc_q;
    logic             flush_valid_q;
    logic [31:0]      flush_pc_q;

    // Payload (not reset; only ever read once valid and resolved)
    logic [30:0]      pc_q     [DEPTH];
    logic [31:0]      pred_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [DEPTH-1:0] taken_q;

    logic do_alloc;
    logic do_resolve;
    logic do_commit;
    logic mispredict;

    // The PC is 2-byte aligned, so bit 0 carries no information.
    logic unused_pc_bit;
    assign unused_pc_bit = bus.alloc_pc[0];

    assign bus.alloc_ready = (count_q != FULL);
    assign bus.alloc_tag   = tail;
    assign bus.count       = count_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.flush_valid = flush_valid_q;
    assign bus.flush_pc    = flush_pc_q;

    // All decisions use registered state from before the edge, so a head that
    // is resolved on this edge cannot also commit on it.
    assign do_alloc   = bus.alloc_valid && bus.alloc_ready;
    assign do_resolve = bus.res_valid && valid_q[bus.res_tag] && !resolved_q[bus.res_tag];
    assign do_commit  = valid_q[head] && resolved_q[head];
    assign mispredict = do_commit && (target_q[head] != pred_q[head]);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q       <= '0;
            resolved_q    <= '0;
            head          <= '0;
            tail          <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            flush_valid_q <= 1'b0;
            flush_pc_q    <= '0;
        end else if (rdy_in) begin
            upd_valid_q   <= do_commit;
            flush_valid_q <= mispredict;
            if (do_commit) begin
                upd_pc_q <= {pc_q[head], taken_q[head]};
            end
            if (mispredict) begin
                flush_pc_q <= target_q[head];
            end

            if (mispredict) begin
                // Everything younger than the mispredicted branch is on the
                // wrong path; same-edge allocate/resolve are dropped as well.
                valid_q <= '0;
                head    <= '0;
                tail    <= '0;
                count_q <= '0;
            end else begin
                // Commit clears head and allocate sets tail; they can only
                // alias when the queue is full, where allocate is blocked.
                if (do_commit) begin
                    valid_q[head] <= 1'b0;
                    head          <= head + PTR_ONE;
                end
                if (do_alloc) begin
                    valid_q[tail]    <= 1'b1;
                    resolved_q[tail] <= 1'b0;
                    tail             <= tail + PTR_ONE;
                end
                if (do_resolve) begin
                    resolved_q[bus.res_tag] <= 1'b1;
                end
                count_q <= count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && !mispredict) begin
            if (do_alloc) begin
                pc_q[tail]   <= bus.alloc_pc[31:1];
                pred_q[tail] <= bus.alloc_pred_pc;
            end
            if (do_resolve) begin
                taken_q[bus.res_tag]  <= bus.res_taken;
                target_q[bus.res_tag] <= bus.res_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_commit_queue.sv
module tb_branch_commit_queue;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    logic rdy;
    int   n_cmp;
    int   n_fail;

    branch_commit_queue_if #(.TAG_W(4)) bus ();

    branch_commit_queue #(.DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic r, input logic av, input logic [31:0] apc,
                         input logic [31:0] apred, input logic rv, input logic [3:0] rtag,
                         input logic rtk, input logic [31:0] rtgt);
        rdy                = r;
        bus.alloc_valid    = av;
        bus.alloc_pc       = apc;
        bus.alloc_pred_pc  = apred;
        bus.res_valid      = rv;
        bus.res_tag        = rtag;
        bus.res_taken      = rtk;
        bus.res_target     = rtgt;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    endtask

    // Sample one time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rdy;
        logic        av;
        logic [31:0] apc;
        logic [31:0] apred;
        logic        rv;
        logic [3:0]  rtag;
        logic        rtk;
        logic [31:0] rtgt;
        logic        e_uv;
        logic [31:0] e_upc;
        logic        e_fv;
        logic [31:0] e_fpc;
        int          e_cnt;
        int          e_tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic av, input logic [31:0] apc, input logic [31:0] apred,
                       input logic rv, input logic [3:0] rtag, input logic rtk, input logic [31:0] rtgt,
                       input logic euv, input logic [31:0] eupc, input logic efv, input logic [31:0] efpc,
                       input int ecnt, input int etag);
        vec_t v;
        v.rdy = r; v.av = av; v.apc = apc; v.apred = apred;
        v.rv = rv; v.rtag = rtag; v.rtk = rtk; v.rtgt = rtgt;
        v.e_uv = euv; v.e_upc = eupc; v.e_fv = efv; v.e_fpc = efpc;
        v.e_cnt = ecnt; v.e_tag = etag;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string nm, input logic euv, input logic [31:0] eupc,
                                 input logic efv, input logic [31:0] efpc, input int ecnt, input int etag);
        chk({nm, ".upd_valid"}, 32'(bus.upd_valid), 32'(euv));
        if (euv) chk({nm, ".upd_pc"}, bus.upd_pc, eupc);
        chk({nm, ".flush_valid"}, 32'(bus.flush_valid), 32'(efv));
        if (efv) chk({nm, ".flush_pc"}, bus.flush_pc, efpc);
        chk({nm, ".count"}, 32'(bus.count), 32'(ecnt));
        chk({nm, ".alloc_tag"}, 32'(bus.alloc_tag), 32'(etag));
        chk({nm, ".alloc_ready"}, 32'(bus.alloc_ready), 32'(ecnt != DEPTH));
    endtask

    // ---------------- reference model ----------------
    // Program-ordered list of live branches; the head tag advances with each
    // retirement, tags of later entries follow by position.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
        logic [31:0] target;
        logic        res;
        logic        taken;
    } ent_t;

    ent_t        m_q[$];
    int          m_head;
    logic        m_uv;
    logic [31:0] m_upc;
    logic        m_fv;
    logic [31:0] m_fpc;

    task automatic model_reset();
        m_q.delete();
        m_head = 0;
        m_uv = 1'b0; m_upc = 32'h0; m_fv = 1'b0; m_fpc = 32'h0;
    endtask

    task automatic model_step(input logic av, input logic [31:0] apc, input logic [31:0] apred,
                              input logic rv, input logic [3:0] rtag, input logic rtk,
                              input logic [31:0] rtgt);
        bit   commit;
        bit   mis;
        int   idx;
        ent_t e;
        commit = (m_q.size() > 0) && m_q[0].res;
        mis = 1'b0;
        m_uv = commit;
        m_fv = 1'b0;
        if (commit) begin
            m_upc = {m_q[0].pc[31:1], m_q[0].taken};
            mis = (m_q[0].target != m_q[0].pred);
            if (mis) begin
                m_fv  = 1'b1;
                m_fpc = m_q[0].target;
            end
        end
        if (mis) begin
            m_q.delete();
            m_head = 0;
            return;
        end
        idx = (int'(rtag) - m_head + DEPTH) % DEPTH;
        if (rv && idx < m_q.size() && !m_q[idx].res) begin
            m_q[idx].res    = 1'b1;
            m_q[idx].taken  = rtk;
            m_q[idx].target = rtgt;
        end
        if (av && m_q.size() < DEPTH) begin
            e.pc = apc; e.pred = apred; e.target = 32'h0; e.res = 1'b0; e.taken = 1'b0;
            m_q.push_back(e);
        end
        if (commit) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
    endtask

    // ---------------- scoreboard for drain sequence ----------------
    logic [31:0] exp_q[$];

    task automatic score_upd();
        if (bus.upd_valid) begin
            if (exp_q.size() == 0) begin
                chk("wrap.extra_update", bus.upd_pc, 32'hFFFF_FFFF);
            end else begin
                chk("wrap.upd_pc", bus.upd_pc, exp_q.pop_front());
            end
        end
        chk("wrap.flush_valid", 32'(bus.flush_valid), 32'h0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic        r, av, rv, rtk;
        logic [31:0] apc, apred, rtgt;
        logic [3:0]  rtag;
        logic [31:0] pc_i;
        int          j;

        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        idle();
        #2;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
        chk("reset.upd_pc", bus.upd_pc, 32'h0);
        chk("reset.flush_pc", bus.flush_pc, 32'h0);
        #10 rst = 1'b0;

        // Correct prediction
        add(1,1,32'h100,32'h104, 0,0,0,32'h0,   0,32'h0,0,32'h0, 1,1);
        add(1,0,32'h0,32'h0,     1,0,0,32'h104, 0,32'h0,0,32'h0, 1,1);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h100,0,32'h0, 0,1);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   0,32'h0,0,32'h0, 0,1);
        // Out-of-order resolve, in-order retirement
        add(1,1,32'h300,32'h400, 0,0,0,32'h0,   0,32'h0,0,32'h0, 1,2);
        add(1,1,32'h310,32'h410, 0,0,0,32'h0,   0,32'h0,0,32'h0, 2,3);
        add(1,1,32'h320,32'h420, 0,0,0,32'h0,   0,32'h0,0,32'h0, 3,4);
        add(1,0,32'h0,32'h0,     1,3,1,32'h420, 0,32'h0,0,32'h0, 3,4);
        add(1,0,32'h0,32'h0,     1,2,1,32'h410, 0,32'h0,0,32'h0, 3,4);
        add(1,0,32'h0,32'h0,     1,1,0,32'h400, 0,32'h0,0,32'h0, 3,4);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h300,0,32'h0, 2,4);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h311,0,32'h0, 1,4);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h321,0,32'h0, 0,4);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   0,32'h0,0,32'h0, 0,4);
        // Mispredict with same-edge allocate/resolve discarded, late resolves ignored
        add(1,1,32'h200,32'h202, 0,0,0,32'h0,   0,32'h0,0,32'h0, 1,5);
        add(1,1,32'h210,32'h212, 0,0,0,32'h0,   0,32'h0,0,32'h0, 2,6);
        add(1,1,32'h220,32'h222, 0,0,0,32'h0,   0,32'h0,0,32'h0, 3,7);
        add(1,0,32'h0,32'h0,     1,4,1,32'h1F0, 0,32'h0,0,32'h0, 3,7);
        add(1,1,32'h230,32'h234, 1,5,0,32'h212, 1,32'h201,1,32'h1F0, 0,0);
        add(1,0,32'h0,32'h0,     1,5,0,32'h212, 0,32'h0,0,32'h0, 0,0);
        add(1,0,32'h0,32'h0,     1,1,0,32'h212, 0,32'h0,0,32'h0, 0,0);
        // Resolve of the tail slot on its own allocation edge is ignored
        add(1,1,32'h500,32'h504, 1,0,0,32'h504, 0,32'h0,0,32'h0, 1,1);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   0,32'h0,0,32'h0, 1,1);
        add(1,0,32'h0,32'h0,     1,0,0,32'h504, 0,32'h0,0,32'h0, 1,1);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h500,0,32'h0, 0,1);
        // Stall: pulse holds, nothing takes effect while rdy is low
        add(1,1,32'h600,32'h604, 0,0,0,32'h0,   0,32'h0,0,32'h0, 1,2);
        add(1,1,32'h610,32'h614, 1,1,0,32'h604, 0,32'h0,0,32'h0, 2,3);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h600,0,32'h0, 1,3);
        for (int k = 0; k < 3; k++)
            add(0,1,32'h620,32'h624, 1,2,1,32'h614, 1,32'h600,0,32'h0, 1,3);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   0,32'h0,0,32'h0, 1,3);
        add(1,0,32'h0,32'h0,     1,2,1,32'h614, 0,32'h0,0,32'h0, 1,3);
        add(1,0,32'h0,32'h0,     0,0,0,32'h0,   1,32'h611,0,32'h0, 0,3);

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].av, vecs[i].apc, vecs[i].apred,
                  vecs[i].rv, vecs[i].rtag, vecs[i].rtk, vecs[i].rtgt);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_uv, vecs[i].e_upc,
                          vecs[i].e_fv, vecs[i].e_fpc, vecs[i].e_cnt, vecs[i].e_tag);
        end

        // Mid-cycle reset with entries queued and an update pulse pending
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h700 + 32'(k * 16), 32'h800, 1'b0, 4'h0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 4'd3, 1'b0, 32'h800);
        tick();
        idle();
        tick();
        chk("prerst.upd_valid", 32'(bus.upd_valid), 32'h1);
        chk("prerst.count", 32'(bus.count), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_outputs("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
        chk("midrst.upd_pc", bus.upd_pc, 32'h0);
        #2 rst = 1'b0;

        // Full queue and pointer wrap
        for (int k = 0; k < DEPTH; k++) begin
            pc_i = 32'h1000 + 32'(k * 4);
            drive(1'b1, 1'b1, pc_i, pc_i + 32'h4, 1'b0, 4'h0, 1'b0, 32'h0);
            tick();
        end
        check_outputs("full", 1'b0, 32'h0, 1'b0, 32'h0, DEPTH, 0);
        drive(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 4'h0, 1'b0, 32'h0);
        tick();
        tick();
        check_outputs("full_hold", 1'b0, 32'h0, 1'b0, 32'h0, DEPTH, 0);
        drive(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b1, 4'h0, 1'b0, 32'h1004);
        tick();
        check_outputs("full_res", 1'b0, 32'h0, 1'b0, 32'h0, DEPTH, 0);
        drive(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 4'h0, 1'b0, 32'h0);
        tick();
        check_outputs("full_commit", 1'b1, 32'h1000, 1'b0, 32'h0, DEPTH - 1, 0);
        tick();
        check_outputs("wrap_alloc", 1'b0, 32'h0, 1'b0, 32'h0, DEPTH, 1);
        for (int k = 1; k < DEPTH; k++)
            exp_q.push_back((32'h1000 + 32'(k * 4)) | 32'(k & 1));
        exp_q.push_back(32'h2000);
        for (int k = 1; k <= DEPTH; k++) begin
            j = k % DEPTH;
            pc_i = (j == 0) ? 32'h2004 : 32'h1004 + 32'(j * 4);
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 4'(j), 1'(j & 1), pc_i);
            tick();
            score_upd();
        end
        idle();
        for (int k = 0; k < 20; k++) begin
            tick();
            score_upd();
        end
        chk("wrap.drain_left", 32'(exp_q.size()), 32'h0);
        chk("wrap.count", 32'(bus.count), 32'h0);
        chk("wrap.alloc_tag", 32'(bus.alloc_tag), 32'h1);

        // Randomised run against the reference model
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            r     = ($urandom_range(0, 7) != 0);
            av    = 1'($urandom_range(0, 1));
            apc   = $urandom & 32'hFFFF_FFFE;
            apred = apc + 32'($urandom_range(1, 8) * 2);
            rv    = ($urandom_range(0, 9) < 7);
            rtk   = 1'($urandom_range(0, 1));
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                j    = $urandom_range(0, m_q.size() - 1);
                rtag = 4'((m_head + j) % DEPTH);
                rtgt = ($urandom_range(0, 15) == 0) ? (m_q[j].pred ^ 32'h10) : m_q[j].pred;
            end else begin
                rtag = 4'($urandom_range(0, DEPTH - 1));
                rtgt = $urandom;
            end
            drive(r, av, apc, apred, rv, rtag, rtk, rtgt);
            if (r) model_step(av, apc, apred, rv, rtag, rtk, rtgt);
            tick();
            check_outputs("rand", m_uv, m_upc, m_fv, m_fpc, m_q.size(), (m_head + m_q.size()) % DEPTH);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
